// File: rtl/getir_hizalayici.sv
// Fetch/align stage: fetches 32-bit words, keeps a 4-halfword buffer, and pre-decodes the head instruction.
// Define SIKISTIRILMIS_BUYRUK_EN for full RV32IC alignment; otherwise every instruction is an aligned 32-bit word.
module getir_hizalayici #(
    parameter logic [17:0] BASLANGIC_PS = 18'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ddb_durdur_i,
    input  logic        yonlendir_i,
    input  logic [17:0] yonlendir_ps_i,
    output logic        bellek_istek_o,
    output logic [16:0] bellek_adres_o,
    input  logic        bellek_istek_hazir_i,
    input  logic        bellek_yanit_gecerli_i,
    input  logic [31:0] bellek_yanit_i,
    output logic        buyruk_gecerli_o,
    output logic [31:0] buyruk_o,
    output logic [17:0] buyruk_ps_o,
    output logic        buyruk_ctipi_o,
    output logic        buyruk_jal_tipi_o,
    output logic        buyruk_jalr_tipi_o,
    output logic        buyruk_dallanma_o,
    output logic [17:0] imm_o,
    output logic        ras_push_o,
    output logic        ras_pop_o
);

`ifdef SIKISTIRILMIS_BUYRUK_EN
    localparam bit CEN = 1'b1;
`else
    localparam bit CEN = 1'b0;
`endif

    typedef enum logic [1:0] {BOSTA, ISTEK, BEKLE, ATIL} durum_t;

    durum_t      durum_q, durum_d;
    logic [63:0] tampon_q, tampon_d;
    logic [2:0]  sayac_q, sayac_d;
    logic [16:0] adres_q, adres_d;
    logic        atla_q, atla_d;
    logic [17:0] ps_q, ps_d;

    logic        bas_c, gecerli, tuket, yanit_al, ekle_iki;
    logic [2:0]  cikar_n, kalan;
    logic [31:0] buyruk_w;
    logic [15:0] ek0, ek1;
    logic [63:0] kaydir;
    logic [17:0] hedef;

    function automatic logic baglanti(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    // Head of the buffer is a 16-bit instruction unless its low bits are 2'b11
    assign bas_c    = CEN && (tampon_q[1:0] != 2'b11);
    assign gecerli  = (bas_c && (sayac_q >= 3'd1)) || (sayac_q >= 3'd2);
    assign buyruk_w = bas_c ? {16'h0, tampon_q[15:0]} : tampon_q[31:0];
    assign tuket    = gecerli && !ddb_durdur_i && !yonlendir_i;
    assign cikar_n  = bas_c ? 3'd1 : 3'd2;
    assign yanit_al = (durum_q == BEKLE) && bellek_yanit_gecerli_i && !yonlendir_i;
    assign ekle_iki = !(CEN && atla_q);
    assign ek0      = ekle_iki ? bellek_yanit_i[15:0] : bellek_yanit_i[31:16];
    assign ek1      = bellek_yanit_i[31:16];
    assign hedef    = CEN ? yonlendir_ps_i : {yonlendir_ps_i[17:1], 1'b0};
    assign kalan    = sayac_q - (tuket ? cikar_n : 3'd0);

    always_comb begin
        kaydir = tampon_q;
        if (tuket) begin
            kaydir = bas_c ? (tampon_q >> 16) : (tampon_q >> 32);
        end
        tampon_d = kaydir;
        for (int i = 0; i < 4; i++) begin
            if (yanit_al && (3'(i) == kalan)) begin
                tampon_d[16*i +: 16] = ek0;
            end
            if (yanit_al && ekle_iki && (3'(i) == kalan + 3'd1)) begin
                tampon_d[16*i +: 16] = ek1;
            end
        end

        sayac_d = kalan + (yanit_al ? (ekle_iki ? 3'd2 : 3'd1) : 3'd0);
        ps_d    = tuket ? ps_q + 18'(cikar_n) : ps_q;
        adres_d = yanit_al ? adres_q + 17'd1 : adres_q;
        atla_d  = yanit_al ? 1'b0 : atla_q;
        if (yonlendir_i) begin
            sayac_d = 3'd0;
            ps_d    = hedef;
            adres_d = yonlendir_ps_i[17:1];
            atla_d  = CEN && yonlendir_ps_i[0];
        end
    end

    always_comb begin
        durum_d = durum_q;
        case (durum_q)
            BOSTA: if (!yonlendir_i && (sayac_q <= 3'd2)) durum_d = ISTEK;
            ISTEK: begin
                if (yonlendir_i) durum_d = bellek_istek_hazir_i ? ATIL : BOSTA;
                else if (bellek_istek_hazir_i) durum_d = BEKLE;
            end
            // A response arriving together with a redirect is simply discarded
            BEKLE: begin
                if (bellek_yanit_gecerli_i) durum_d = BOSTA;
                else if (yonlendir_i) durum_d = ATIL;
            end
            ATIL:  if (bellek_yanit_gecerli_i) durum_d = BOSTA;
            default: durum_d = BOSTA;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            durum_q <= BOSTA;
            sayac_q <= 3'd0;
            adres_q <= BASLANGIC_PS[17:1];
            atla_q  <= CEN && BASLANGIC_PS[0];
            ps_q    <= CEN ? BASLANGIC_PS : {BASLANGIC_PS[17:1], 1'b0};
        end else begin
            durum_q <= durum_d;
            sayac_q <= sayac_d;
            adres_q <= adres_d;
            atla_q  <= atla_d;
            ps_q    <= ps_d;
        end
    end

    always_ff @(posedge clk_i) begin
        tampon_q <= tampon_d;
    end

    assign bellek_istek_o = (durum_q == ISTEK);
    assign bellek_adres_o = adres_q;
    assign buyruk_gecerli_o = gecerli;
    assign buyruk_o    = gecerli ? buyruk_w : 32'h0;
    assign buyruk_ps_o = ps_q;

    logic [15:0] cb;
    logic [4:0]  rd, rs1;
    assign cb  = buyruk_w[15:0];
    assign rd  = buyruk_w[11:7];
    assign rs1 = buyruk_w[19:15];

    always_comb begin
        buyruk_ctipi_o     = 1'b0;
        buyruk_jal_tipi_o  = 1'b0;
        buyruk_jalr_tipi_o = 1'b0;
        buyruk_dallanma_o  = 1'b0;
        imm_o              = 18'h0;
        ras_push_o         = 1'b0;
        ras_pop_o          = 1'b0;
        if (gecerli && bas_c) begin
            buyruk_ctipi_o = 1'b1;
            if (cb[1:0] == 2'b01 && cb[14:13] == 2'b01) begin
                // c.j (101) and c.jal (001)
                buyruk_jal_tipi_o = 1'b1;
                ras_push_o        = !cb[15];
                imm_o = {{7{cb[12]}}, cb[12], cb[8], cb[10:9], cb[6], cb[7], cb[2], cb[11], cb[5:3]};
            end else if (cb[1:0] == 2'b10 && cb[15:13] == 3'b100 && cb[6:2] == 5'd0
                         && cb[11:7] != 5'd0) begin
                buyruk_jalr_tipi_o = 1'b1;
                ras_push_o         = cb[12];
                ras_pop_o          = !cb[12] && baglanti(cb[11:7]);
            end else if (cb[1:0] == 2'b01 && cb[15:14] == 2'b11) begin
                buyruk_dallanma_o = 1'b1;
                imm_o = {{10{cb[12]}}, cb[12], cb[6:5], cb[2], cb[11:10], cb[4:3]};
            end
        end else if (gecerli) begin
            case (buyruk_w[6:0])
                7'b1101111: begin
                    buyruk_jal_tipi_o = 1'b1;
                    ras_push_o        = baglanti(rd);
                    imm_o = {buyruk_w[18:12], buyruk_w[20], buyruk_w[30:21]};
                end
                7'b1100111: begin
                    buyruk_jalr_tipi_o = 1'b1;
                    ras_push_o         = baglanti(rd);
                    ras_pop_o          = baglanti(rs1) && !baglanti(rd);
                    imm_o = {{7{buyruk_w[31]}}, buyruk_w[31:21]};
                end
                7'b1100011: begin
                    buyruk_dallanma_o = 1'b1;
                    imm_o = {{6{buyruk_w[31]}}, buyruk_w[31], buyruk_w[7],
                             buyruk_w[30:25], buyruk_w[11:8]};
                end
                default: ;
            endcase
        end
    end

endmodule
